prbs9_checker: RTL and testbench
================================

# prbs9_checker

PRBS9 receive-side checker sitting directly downstream of the PRBS9 generator. It consumes the generated serial bit stream (x^9 + x^5 + 1, recurrence b[n] = b[n-9] ^ b[n-5]) on qualified cycles, self-synchronises to any phase or seed, and declares lock. Once locked it counts received bits and bit errors for BER measurement, and drops lock on excessive error density.

## Interface
Parameters:
- LOCK_CNT, 16: consecutive matching bits required in SYNC before declaring lock (1..255).
- WINDOW, 64: length, in qualified bits, of the unlock observation window (2..65535).
- UNLOCK_ERR, 8: error count within one window that forces loss of lock (1..WINDOW).
- CNT_W, 32: width of the bit and error counters.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- enable  in  1  block enable; bit is qualified only when enable && i_valid.
- i_valid  in  1  input bit valid strobe.
- bit_in  in  1  received serial bit.
- i_clear  in  1  synchronous clear of o_bit_count and o_err_count; does not affect lock.
- o_locked  out  1  high while in LOCKED.
- o_err  out  1  one-cycle pulse, one cycle after a qualified mismatching bit while LOCKED.
- o_bit_count  out  CNT_W  qualified bits checked while LOCKED, saturating.
- o_err_count  out  CNT_W  mismatches while LOCKED, saturating.

## Operation
- Qualified cycle (q) = enable && i_valid. On non-q cycles, all state, counters and history hold, and o_err = 0.
- History register h[8:0]: h[k] = bit received k+1 qualified cycles ago. Prediction p = h[8] ^ h[4]. On each q, shift h <= {h[7:0], s}, where s is selected by state as described below.
- FSM states: FILL, SYNC, LOCKED. Reset state is FILL.
- FILL: s = bit_in. Count 9 qualified bits, then go to SYNC with the match counter at 0.
- SYNC: s = bit_in. If bit_in == p, increment the match counter. When it reaches LOCK_CNT, go to LOCKED. On a mismatch, clear the match counter and stay in SYNC. History is always reloaded from the line, so the checker self-synchronises.
- LOCKED: s = p. The history free-runs as a local generator, so one line bit error counts exactly once. On each q:
  - o_bit_count += 1.
  - On mismatch, o_err_count += 1 and assert o_err on the next cycle.
  - The window counter increments and the window error counter increments on mismatch.
  - The window error counter reaching UNLOCK_ERR sends the FSM to FILL, clearing the window, match and fill counters.
  - The window counter reaching WINDOW restarts both window counters. If the last bit of a window is the UNLOCK_ERR-th error, unlock takes priority.
- Counters saturate at 2^CNT_W-1 and never wrap.
- i_clear coincident with a count increment: clear wins, so the result is 0.
- Counters are not cleared on unlock; they accumulate across relocks until i_clear or reset.

## Timing
- Reset (asynchronous) values:
  - state = FILL, h = 0, all internal counters = 0.
  - o_locked = 0, o_err = 0, o_bit_count = 0, o_err_count = 0.
- All outputs are registered.
- o_locked rises in the cycle after the LOCK_CNT-th consecutive match.
- Minimum time to lock is 9 + LOCK_CNT qualified bits from reset on a clean stream.
- o_err and the counter updates are visible 1 clock after the qualifying edge.
- Reset asserted mid-operation aborts immediately. Operation resumes in FILL on the first clk edge after deassertion.

## Structure
- Shared package prbs9_pkg holds:
  - PRBS9_LEN = 9, TAP_A = 8, TAP_B = 4.
  - The FSM state enum {FILL, SYNC, LOCKED}.
  - The generator seed constant 9'h1AA.
- One sub-module, prbs9_sat_cnt: a CNT_W saturating counter with inc and clr inputs (clr priority). It is instantiated twice, for bits and errors.

## Test plan
- Clean stream: drive the PRBS9 generator (seed 0x1AA) with q every cycle for 200 bits.
  - o_locked rises after bit 25.
  - o_err_count = 0 throughout.
  - o_bit_count = 175 at the end.
- Single injected error: invert one bit at bit 100 of a clean locked stream.
  - Exactly one o_err pulse.
  - o_err_count = 1.
  - Lock is held.
- Error burst: invert 8 bits within one 64-bit window.
  - o_locked falls after the 8th error.
  - Relock occurs after 9+16 further clean bits.
  - o_err_count = 8.
- Gapped valid: toggle i_valid 1/0 and hold enable low on random cycles.
  - Lock and count behaviour matches the ungapped case, counted in qualified bits.
  - o_err stays 0 on non-q cycles.
- Saturation and clear: with CNT_W=4, run 30 clean locked bits.
  - o_bit_count holds at 15.
  - Asserting i_clear together with a q returns 0.
- Reset mid-lock: assert reset while locked.
  - All outputs are 0 immediately.
  - Relock occurs 25 qualified bits after release.

Source files
------------

// File: rtl/prbs9_pkg.sv
// Shared PRBS9 definitions: polynomial taps (x^9 + x^5 + 1), generator seed,
// checker FSM state encoding and the one-step prediction helper.
package prbs9_pkg;

  localparam int unsigned PRBS9_LEN = 9;
  localparam int unsigned TAP_A     = 8;
  localparam int unsigned TAP_B     = 4;

  localparam logic [PRBS9_LEN-1:0] PRBS9_SEED = 9'h1AA;

  typedef enum logic [1:0] {
    FILL   = 2'd0,
    SYNC   = 2'd1,
    LOCKED = 2'd2
  } prbs9_state_e;

  // h[k] holds the bit seen k+1 steps ago, so b[n] = b[n-9] ^ b[n-5] = h[8] ^ h[4].
  function automatic logic prbs9_predict(input logic [PRBS9_LEN-1:0] h);
    return h[TAP_A] ^ h[TAP_B];
  endfunction

endpackage

// File: rtl/prbs9_sat_cnt.sv
// Saturating up-counter with synchronous clear (clear has priority).
//   clk, reset : clock, async active-high reset
//   inc_i      : increment request
//   clr_i      : synchronous clear
//   cnt_o      : registered count, holds at all-ones
module prbs9_sat_cnt
  import prbs9_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc_i,
  input  logic             clr_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (inc_i && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/prbs9_checker.sv
// PRBS9 receive checker: self-synchronises to the incoming stream, declares
// lock, then counts bits/errors and drops lock on excessive error density.
//   clk, reset   : clock, async active-high reset
//   enable       : block enable (bit qualified when enable && i_valid)
//   i_valid      : input bit strobe
//   bit_in       : received serial bit
//   i_clear      : synchronous clear of both counters
//   o_locked     : high while locked
//   o_err        : one-cycle pulse after a mismatching bit while locked
//   o_bit_count  : bits checked while locked (saturating)
//   o_err_count  : mismatches while locked (saturating)
module prbs9_checker
  import prbs9_pkg::*;
#(
  parameter int unsigned LOCK_CNT   = 16,
  parameter int unsigned WINDOW     = 64,
  parameter int unsigned UNLOCK_ERR = 8,
  parameter int unsigned CNT_W      = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             i_valid,
  input  logic             bit_in,
  input  logic             i_clear,
  output logic             o_locked,
  output logic             o_err,
  output logic [CNT_W-1:0] o_bit_count,
  output logic [CNT_W-1:0] o_err_count
);

  localparam int unsigned FILL_W  = 4;
  localparam int unsigned MATCH_W = 8;
  localparam int unsigned WIN_W   = 16;

  prbs9_state_e          state_q;
  logic [PRBS9_LEN-1:0]  hist_q;
  logic [FILL_W-1:0]     fill_cnt_q;
  logic [MATCH_W-1:0]    match_cnt_q;
  logic [WIN_W-1:0]      win_cnt_q;
  logic [WIN_W-1:0]      win_err_q;
  logic                  locked_q;
  logic                  err_q;

  logic                  qual_c;
  logic                  pred_c;
  logic                  mism_c;
  logic                  shift_bit_c;
  logic                  cnt_bit_c;
  logic                  cnt_err_c;
  logic [WIN_W-1:0]      win_cnt_inc_c;
  logic [WIN_W-1:0]      win_err_inc_c;

  assign qual_c        = enable & i_valid;
  assign pred_c        = prbs9_predict(hist_q);
  assign mism_c        = bit_in ^ pred_c;
  // Once locked the history free-runs on its own prediction, so a single
  // corrupted line bit is counted once rather than echoing through the taps.
  assign shift_bit_c   = (state_q == LOCKED) ? pred_c : bit_in;
  assign win_cnt_inc_c = win_cnt_q + WIN_W'(1);
  assign win_err_inc_c = win_err_q + WIN_W'(mism_c);
  assign cnt_bit_c     = qual_c && (state_q == LOCKED);
  assign cnt_err_c     = cnt_bit_c && mism_c;

  // Lock FSM, history shift register and unlock window tracking.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= FILL;
      hist_q      <= '0;
      fill_cnt_q  <= '0;
      match_cnt_q <= '0;
      win_cnt_q   <= '0;
      win_err_q   <= '0;
      locked_q    <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      err_q <= 1'b0;
      if (qual_c) begin
        hist_q <= {hist_q[PRBS9_LEN-2:0], shift_bit_c};
        case (state_q)
          FILL: begin
            if (fill_cnt_q == FILL_W'(PRBS9_LEN - 1)) begin
              state_q     <= SYNC;
              fill_cnt_q  <= '0;
              match_cnt_q <= '0;
            end else begin
              fill_cnt_q <= fill_cnt_q + FILL_W'(1);
            end
          end
          SYNC: begin
            if (mism_c) begin
              match_cnt_q <= '0;
            end else if (match_cnt_q == MATCH_W'(LOCK_CNT - 1)) begin
              state_q     <= LOCKED;
              locked_q    <= 1'b1;
              match_cnt_q <= '0;
              win_cnt_q   <= '0;
              win_err_q   <= '0;
            end else begin
              match_cnt_q <= match_cnt_q + MATCH_W'(1);
            end
          end
          LOCKED: begin
            err_q <= mism_c;
            // Unlock is checked before window rollover so an error on the
            // last bit of a window still counts toward that window.
            if (win_err_inc_c == WIN_W'(UNLOCK_ERR)) begin
              state_q     <= FILL;
              locked_q    <= 1'b0;
              fill_cnt_q  <= '0;
              match_cnt_q <= '0;
              win_cnt_q   <= '0;
              win_err_q   <= '0;
            end else if (win_cnt_inc_c == WIN_W'(WINDOW)) begin
              win_cnt_q <= '0;
              win_err_q <= '0;
            end else begin
              win_cnt_q <= win_cnt_inc_c;
              win_err_q <= win_err_inc_c;
            end
          end
          default: begin
            state_q  <= FILL;
            locked_q <= 1'b0;
          end
        endcase
      end
    end
  end

  prbs9_sat_cnt #(.CNT_W(CNT_W)) u_bit_cnt (
    .clk   (clk),
    .reset (reset),
    .inc_i (cnt_bit_c),
    .clr_i (i_clear),
    .cnt_o (o_bit_count)
  );

  prbs9_sat_cnt #(.CNT_W(CNT_W)) u_err_cnt (
    .clk   (clk),
    .reset (reset),
    .inc_i (cnt_err_c),
    .clr_i (i_clear),
    .cnt_o (o_err_count)
  );

  assign o_locked = locked_q;
  assign o_err    = err_q;

endmodule

// File: tb/tb_prbs9_checker.sv
// Directed bench for prbs9_checker: clean lock, single error, error bursts
// around window edges, gapped qualification, saturation/clear, async reset.
module tb_prbs9_checker;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic        i_valid;
  logic        bit_in;
  logic        i_clear;
  logic        o_locked;
  logic        o_err;
  logic [31:0] o_bit_count;
  logic [31:0] o_err_count;
  logic        s_locked;
  logic        s_err;
  logic [3:0]  s_bit_count;
  logic [3:0]  s_err_count;

  logic [8:0]  gen_q;
  int          bit_idx;
  int          err_pulses;
  int          nonq_err;
  int          n_total;
  int          n_bad;

  always #5 clk = ~clk;

  prbs9_checker u_dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .i_valid     (i_valid),
    .bit_in      (bit_in),
    .i_clear     (i_clear),
    .o_locked    (o_locked),
    .o_err       (o_err),
    .o_bit_count (o_bit_count),
    .o_err_count (o_err_count)
  );

  prbs9_checker #(.CNT_W(4)) u_dut4 (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .i_valid     (i_valid),
    .bit_in      (bit_in),
    .i_clear     (i_clear),
    .o_locked    (s_locked),
    .o_err       (s_err),
    .o_bit_count (s_bit_count),
    .o_err_count (s_err_count)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One clock: drive inputs, clock edge, sample 1 time unit later.
  task automatic step(input logic v, input logic e, input logic inj, input logic clr);
    logic b;
    b       = gen_q[8] ^ gen_q[4];
    bit_in  = b ^ inj;
    i_valid = v;
    enable  = e;
    i_clear = clr;
    @(posedge clk);
    #1;
    if (v && e) begin
      gen_q = {gen_q[7:0], b};
      bit_idx++;
    end
    if (o_err) err_pulses++;
    if (o_err && !(v && e)) nonq_err++;
    i_clear = 1'b0;
  endtask

  task automatic qbit(input logic inj);
    step(1'b1, 1'b1, inj, 1'b0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset      = 1'b0;
    bit_idx    = 0;
    err_pulses = 0;
    nonq_err   = 0;
  endtask

  initial begin
    n_total    = 0;
    n_bad      = 0;
    gen_q      = 9'h1AA;
    enable     = 1'b0;
    i_valid    = 1'b0;
    bit_in     = 1'b0;
    i_clear    = 1'b0;
    reset      = 1'b1;
    bit_idx    = 0;
    err_pulses = 0;
    nonq_err   = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_locked", 32'(o_locked), 32'd0);
    chk("rst_err", 32'(o_err), 32'd0);
    chk("rst_bitcnt", o_bit_count, 32'd0);
    chk("rst_errcnt", o_err_count, 32'd0);
    reset = 1'b0;

    // Clean stream: lock after bit 25, 175 counted bits by bit 200.
    for (int i = 1; i <= 200; i++) begin
      qbit(1'b0);
      if (i == 24) chk("clean_lock_b24", 32'(o_locked), 32'd0);
      if (i == 25) chk("clean_lock_b25", 32'(o_locked), 32'd1);
      if (i == 25) chk("sat_lock_b25", 32'(s_locked), 32'd1);
      if (i == 55) chk("sat_bitcnt", 32'(s_bit_count), 32'd15);
    end
    chk("clean_bitcnt", o_bit_count, 32'd175);
    chk("clean_errcnt", o_err_count, 32'd0);
    chk("clean_pulses", 32'(err_pulses), 32'd0);
    chk("clean_locked", 32'(o_locked), 32'd1);
    chk("sat_hold", 32'(s_bit_count), 32'd15);
    step(1'b1, 1'b1, 1'b0, 1'b1);
    chk("clr_bitcnt", o_bit_count, 32'd0);
    chk("clr_satcnt", 32'(s_bit_count), 32'd0);
    qbit(1'b0);
    chk("post_clr_bitcnt", o_bit_count, 32'd1);

    // Single injected error at bit 100.
    do_reset();
    for (int i = 1; i <= 200; i++) begin
      qbit(i == 100);
      if (i == 100) chk("single_err_pulse", 32'(o_err), 32'd1);
      if (i == 101) chk("single_err_drop", 32'(o_err), 32'd0);
    end
    chk("single_pulses", 32'(err_pulses), 32'd1);
    chk("single_errcnt", o_err_count, 32'd1);
    chk("single_locked", 32'(o_locked), 32'd1);
    chk("single_bitcnt", o_bit_count, 32'd175);

    // Burst of 8 errors (bits 30..44 even) inside the first window.
    do_reset();
    for (int i = 1; i <= 69; i++) begin
      qbit((i >= 30) && (i <= 44) && (i % 2 == 0));
      if (i == 43) chk("burst_lock_b43", 32'(o_locked), 32'd1);
      if (i == 44) chk("burst_unlock_b44", 32'(o_locked), 32'd0);
      if (i == 68) chk("burst_relock_b68", 32'(o_locked), 32'd0);
    end
    chk("burst_relock_b69", 32'(o_locked), 32'd1);
    chk("burst_errcnt", o_err_count, 32'd8);
    chk("burst_bitcnt", o_bit_count, 32'd19);

    // 7 errors end of window 1 (83..89) + 1 at start of window 2: no unlock.
    do_reset();
    for (int i = 1; i <= 90; i++) qbit((i >= 83) && (i <= 90));
    chk("win_split_locked", 32'(o_locked), 32'd1);
    chk("win_split_errcnt", o_err_count, 32'd8);

    // 8th error on last bit of window 1 (82..89): unlock wins over rollover.
    do_reset();
    for (int i = 1; i <= 114; i++) begin
      qbit((i >= 82) && (i <= 89));
      if (i == 88) chk("win_edge_b88", 32'(o_locked), 32'd1);
      if (i == 89) chk("win_edge_b89", 32'(o_locked), 32'd0);
      if (i == 113) chk("win_edge_b113", 32'(o_locked), 32'd0);
    end
    chk("win_edge_relock", 32'(o_locked), 32'd1);

    // Gapped qualification, one error at qualified bit 100.
    do_reset();
    for (int c = 0; (c < 3000) && (bit_idx < 200); c++) begin
      logic v;
      logic e;
      v = 1'($urandom_range(0, 1));
      e = ($urandom_range(0, 3) != 0);
      step(v, e, (v && e) && (bit_idx + 1 == 100), 1'b0);
      if ((v && e) && (bit_idx == 24)) chk("gap_lock_b24", 32'(o_locked), 32'd0);
      if ((v && e) && (bit_idx == 25)) chk("gap_lock_b25", 32'(o_locked), 32'd1);
    end
    chk("gap_budget", 32'(bit_idx), 32'd200);
    chk("gap_bitcnt", o_bit_count, 32'd175);
    chk("gap_errcnt", o_err_count, 32'd1);
    chk("gap_pulses", 32'(err_pulses), 32'd1);
    chk("gap_nonq_err", 32'(nonq_err), 32'd0);

    // Async reset while locked, then relock 25 qualified bits later.
    for (int i = 1; i <= 50; i++) qbit(i == 40);
    chk("prerst_locked", 32'(o_locked), 32'd1);
    #3;
    reset = 1'b1;
    #1;
    chk("midrst_locked", 32'(o_locked), 32'd0);
    chk("midrst_err", 32'(o_err), 32'd0);
    chk("midrst_bitcnt", o_bit_count, 32'd0);
    chk("midrst_errcnt", o_err_count, 32'd0);
    chk("midrst_satcnt", 32'(s_bit_count), 32'd0);
    @(posedge clk);
    #1;
    reset   = 1'b0;
    bit_idx = 0;
    for (int i = 1; i <= 25; i++) begin
      qbit(1'b0);
      if (i == 24) chk("rst_relock_b24", 32'(o_locked), 32'd0);
    end
    chk("rst_relock_b25", 32'(o_locked), 32'd1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
